// File: rtl/s_box_inverse.sv
// AES inverse S-box, one byte per transaction: inverse affine at capture, then
// b^254 by seven square/multiply rounds through one shared GF(2^8) multiplier.
module s_box_inverse (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready
);

    // state | meaning
    // IDLE  | waiting for a byte, iready high
    // SQR   | base <= base^2
    // MUL   | acc <= acc*base, seven rounds total
    // DONE  | result held on odata until oready
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] base;
    logic [7:0] acc;
    logic [2:0] cnt;
    logic [7:0] mul_a;
    logic [7:0] prod;
    logic [7:0] inv_aff;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i])
                p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    assign inv_aff = {idata[6:0], idata[7]} ^ {idata[4:0], idata[7:5]}
                   ^ {idata[1:0], idata[7:2]} ^ 8'h05;

    // The single multiplier squares base in SQR and folds it into acc in MUL.
    assign mul_a = (state == MUL) ? acc : base;
    assign prod  = gf_mul(mul_a, base);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ivalid) state_nxt = SQR;
            SQR:  state_nxt = MUL;
            MUL:  state_nxt = (cnt == 3'd6) ? DONE : SQR;
            DONE: if (oready) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        iready = (state == IDLE);
        ovalid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base  <= 8'h00;
            acc   <= 8'h00;
            cnt   <= 3'd0;
            odata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (ivalid) begin
                        base <= inv_aff;
                        acc  <= 8'h01;
                        cnt  <= 3'd0;
                    end
                end
                SQR: base <= prod;
                MUL: begin
                    acc <= prod;
                    if (cnt == 3'd6)
                        odata <= prod;
                    else
                        cnt <= cnt + 3'd1;
                end
                DONE: ;
            endcase
        end
    end

endmodule
